// File: rtl/kd_sort_scheduler_pkg.sv
// kd_sort_scheduler_pkg: FSM and phase encodings plus the even-level mask helper
// shared by the sort scheduler and the node-array generate code.
package kd_sort_scheduler_pkg;

   typedef enum logic [2:0] {S_IDLE, S_EN, S_SETTLE, S_CHECK, S_DONE} state_e;
   typedef enum logic {PHASE_EVEN, PHASE_ODD} phase_e;

   function automatic logic [31:0] even_mask(input int depth);
      logic [31:0] m;
      for (int i = 0; i < 32; i++) m[i] = (i < depth) && (i % 2 == 0);
      return m;
   endfunction

endpackage

// File: rtl/kd_sort_scheduler.sv
// kd_sort_scheduler: alternates even/odd level compare-exchange phases over the kd_tree
// node array until two consecutive clean phases (converged) or max_iter passes (timeout).
module kd_sort_scheduler
   import kd_sort_scheduler_pkg::*;
#(
   parameter int MAX_DEPTH     = 4,
   parameter int MAX_ITER      = 64,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_i,
   input  logic [MAX_DEPTH-1:0]            level_stable_i,
   output logic [MAX_DEPTH-1:0]            level_en_o,
   output logic                            sorting_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            converged_o,
   output logic                            timeout_o,
   output logic [$clog2(MAX_ITER+1)-1:0]   iter_count_o
);

   localparam int IW = $clog2(MAX_ITER + 1);
   localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [31:0] EVEN32 = even_mask(MAX_DEPTH);
   localparam logic [MAX_DEPTH-1:0] EVEN_M = EVEN32[MAX_DEPTH-1:0];
   localparam logic [MAX_DEPTH-1:0] ODD_M = ~EVEN_M;

   state_e               state_q, state_d;
   phase_e               phase_q, phase_d;
   logic [SW-1:0]        settle_q, settle_d;
   logic [IW-1:0]        iter_q, iter_d, iter_nx;
   logic [1:0]           clean_q, clean_d, clean_nx;
   logic                 conv_q, conv_d, tmo_q, tmo_d;
   logic [MAX_DEPTH-1:0] mask;
   logic                 clean;

   // An empty mask (odd phase with a single level) reduces to a trivially clean phase.
   assign mask     = phase_q == PHASE_ODD ? ODD_M : EVEN_M;
   assign clean    = &(level_stable_i | ~mask);
   assign clean_nx = !clean ? 2'd0 : clean_q == 2'd2 ? 2'd2 : clean_q + 2'd1;
   assign iter_nx  = phase_q == PHASE_ODD ? iter_q + IW'(1) : iter_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         phase_q  <= PHASE_EVEN;
         settle_q <= '0;
         iter_q   <= '0;
         clean_q  <= '0;
         conv_q   <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         settle_q <= settle_d;
         iter_q   <= iter_d;
         clean_q  <= clean_d;
         conv_q   <= conv_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      settle_d = settle_q;
      iter_d   = iter_q;
      clean_d  = clean_q;
      conv_d   = conv_q;
      tmo_d    = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_EN;
               phase_d = PHASE_EVEN;
               iter_d  = '0;
               clean_d = '0;
               conv_d  = 1'b0;
               tmo_d   = 1'b0;
            end
         end
         S_EN: begin
            state_d  = S_SETTLE;
            settle_d = '0;
         end
         S_SETTLE: begin
            settle_d = settle_q + SW'(1);
            state_d  = settle_q == SW'(SETTLE_CYCLES - 1) ? S_CHECK : S_SETTLE;
         end
         S_CHECK: begin
            clean_d = clean_nx;
            iter_d  = iter_nx;
            if (clean_nx == 2'd2) begin
               state_d = S_DONE;
               conv_d  = 1'b1;
            end else if (phase_q == PHASE_ODD && iter_nx == IW'(MAX_ITER)) begin
               state_d = S_DONE;
               tmo_d   = 1'b1;
            end else begin
               state_d = S_EN;
               phase_d = phase_q == PHASE_EVEN ? PHASE_ODD : PHASE_EVEN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      level_en_o   = state_q == S_EN ? mask : '0;
      sorting_o    = state_q == S_EN || state_q == S_SETTLE || state_q == S_CHECK;
      busy_o       = state_q != S_IDLE;
      done_o       = state_q == S_DONE;
      converged_o  = conv_q;
      timeout_o    = tmo_q;
      iter_count_o = iter_q;
   end

endmodule

// File: tb/tb_kd_sort_scheduler.sv
// tb_kd_sort_scheduler: directed runs on three scheduler configurations; expected enable/done
// events are queued by the stimulus and matched by per-DUT monitors on the falling edge.
module tb_kd_sort_scheduler;

   typedef struct packed {
      logic [31:0] cyc;
      logic [4:0]  en;
      logic        done;
      logic        sorting;
      logic        busy;
      logic        conv;
      logic        tmo;
      logic [6:0]  iter;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] st;
   logic [3:0] ls_a;
   logic [4:0] ls_b;
   logic [0:0] ls_c;

   logic [3:0] en_a;
   logic [4:0] en_b;
   logic [0:0] en_c;
   logic       sort_a, busy_a, done_a, conv_a, tmo_a;
   logic       sort_b, busy_b, done_b, conv_b, tmo_b;
   logic       sort_c, busy_c, done_c, conv_c, tmo_c;
   logic [2:0] iter_a, iter_c;
   logic [6:0] iter_b;

   kd_sort_scheduler #(.MAX_DEPTH(4), .MAX_ITER(4), .SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .start_i(st[0]), .level_stable_i(ls_a), .level_en_o(en_a),
      .sorting_o(sort_a), .busy_o(busy_a), .done_o(done_a), .converged_o(conv_a),
      .timeout_o(tmo_a), .iter_count_o(iter_a));

   kd_sort_scheduler #(.MAX_DEPTH(5), .MAX_ITER(64), .SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .start_i(st[1]), .level_stable_i(ls_b), .level_en_o(en_b),
      .sorting_o(sort_b), .busy_o(busy_b), .done_o(done_b), .converged_o(conv_b),
      .timeout_o(tmo_b), .iter_count_o(iter_b));

   kd_sort_scheduler #(.MAX_DEPTH(1), .MAX_ITER(4), .SETTLE_CYCLES(1)) dut_c (
      .clk(clk), .rst(rst), .start_i(st[2]), .level_stable_i(ls_c), .level_en_o(en_c),
      .sorting_o(sort_c), .busy_o(busy_c), .done_o(done_c), .converged_o(conv_c),
      .timeout_o(tmo_c), .iter_count_o(iter_c));

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   ev_t q_a[$], q_b[$], q_c[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t ev(int c, logic [4:0] en, logic dn, logic srt, logic bsy,
                              logic cv, logic to, logic [6:0] it);
      ev_t e;
      e.cyc = c;
      e.en = en;
      e.done = dn;
      e.sorting = srt;
      e.busy = bsy;
      e.conv = cv;
      e.tmo = to;
      e.iter = it;
      return e;
   endfunction

   // EN and DONE are the only observed events; both are busy, sorting only in EN.
   function automatic ev_t xp(int c, logic [4:0] en, logic dn, logic cv, logic to, logic [6:0] it);
      return ev(c, en, dn, !dn, 1'b1, cv, to, it);
   endfunction

   function automatic string fmt(ev_t e);
      return $sformatf("cyc=%0d en=%b done=%b sort=%b busy=%b conv=%b tmo=%b iter=%0d",
                       e.cyc, e.en, e.done, e.sorting, e.busy, e.conv, e.tmo, e.iter);
   endfunction

   function automatic int qsize(int id);
      return id == 0 ? q_a.size() : id == 1 ? q_b.size() : q_c.size();
   endfunction

   task automatic push(int id, ev_t e);
      case (id)
         0: q_a.push_back(e);
         1: q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic check(int id, ev_t got);
      ev_t e;
      bit have;
      have = qsize(id) > 0;
      if (have) begin
         case (id)
            0: e = q_a.pop_front();
            1: e = q_b.pop_front();
            default: e = q_c.pop_front();
         endcase
      end
      n_cmp++;
      if (!have) begin
         n_bad++;
         $display("FAIL dut%0d unexpected_event got %s", id, fmt(got));
      end else if (got !== e) begin
         n_bad++;
         $display("FAIL dut%0d event got %s expected %s", id, fmt(got), fmt(e));
      end
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic drain(int id, int budget);
      for (int k = 0; k < budget && qsize(id) != 0; k++) @(negedge clk);
      n_cmp++;
      if (qsize(id) != 0) begin
         n_bad++;
         $display("FAIL dut%0d drain got %0d pending expected 0", id, qsize(id));
         case (id)
            0: q_a.delete();
            1: q_b.delete();
            default: q_c.delete();
         endcase
      end
   endtask

   task automatic wait_cyc(int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic go(int id, output int s);
      @(negedge clk);
      s = cyc;
      st[id] = 1'b1;
   endtask

   always @(negedge clk)
      if (en_a != '0 || done_a)
         check(0, ev(cyc, 5'(en_a), done_a, sort_a, busy_a, conv_a, tmo_a, 7'(iter_a)));

   always @(negedge clk)
      if (en_b != '0 || done_b)
         check(1, ev(cyc, en_b, done_b, sort_b, busy_b, conv_b, tmo_b, iter_b));

   always @(negedge clk)
      if (en_c != '0 || done_c)
         check(2, ev(cyc, 5'(en_c), done_c, sort_c, busy_c, conv_c, tmo_c, 7'(iter_c)));

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int s;
      rst = 1'b1;
      st = '0;
      ls_a = '0;
      ls_b = '0;
      ls_c = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy_a, 0);
      chk("reset_level_en", en_a, 0);
      chk("reset_sorting", sort_a, 0);
      chk("reset_iter", iter_a, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // fastest convergence, all levels stable
      ls_a = 4'hF;
      go(0, s);
      push(0, xp(s + 1, 5'b00101, 0, 0, 0, 0));
      push(0, xp(s + 4, 5'b01010, 0, 0, 0, 0));
      push(0, xp(s + 7, 5'b00000, 1, 1, 0, 1));
      @(negedge clk);
      st[0] = 1'b0;
      drain(0, 20);
      wait_cyc(s + 9);
      chk("t1_conv_hold", conv_a, 1);
      chk("t1_iter_hold", iter_a, 1);
      chk("t1_busy_idle", busy_a, 0);

      // first even CHECK unclean, then convergence across the odd->even boundary
      go(0, s);
      ls_a = 4'b1010;
      push(0, xp(s + 1, 5'b00101, 0, 0, 0, 0));
      push(0, xp(s + 4, 5'b01010, 0, 0, 0, 0));
      push(0, xp(s + 7, 5'b00101, 0, 0, 0, 1));
      push(0, xp(s + 10, 5'b00000, 1, 1, 0, 1));
      @(negedge clk);
      st[0] = 1'b0;
      wait_cyc(s + 4);
      ls_a = 4'hF;
      drain(0, 20);
      repeat (3) @(negedge clk);

      // never stable: timeout after MAX_ITER=4 passes
      go(0, s);
      ls_a = 4'h0;
      for (int k = 0; k < 4; k++) begin
         push(0, xp(s + 6 * k + 1, 5'b00101, 0, 0, 0, 7'(k)));
         push(0, xp(s + 6 * k + 4, 5'b01010, 0, 0, 0, 7'(k)));
      end
      push(0, xp(s + 25, 5'b00000, 1, 0, 1, 4));
      @(negedge clk);
      st[0] = 1'b0;
      drain(0, 40);
      wait_cyc(s + 27);
      chk("t3_tmo_hold", tmo_a, 1);
      chk("t3_conv_hold", conv_a, 0);
      chk("t3_iter_hold", iter_a, 4);

      // reset mid-run aborts with no done pulse
      ls_a = 4'hF;
      go(0, s);
      push(0, xp(s + 1, 5'b00101, 0, 0, 0, 0));
      push(0, xp(s + 4, 5'b01010, 0, 0, 0, 0));
      @(negedge clk);
      st[0] = 1'b0;
      wait_cyc(s + 5);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_busy", busy_a, 0);
      chk("t4_sorting", sort_a, 0);
      chk("t4_done", done_a, 0);
      chk("t4_level_en", en_a, 0);
      chk("t4_iter", iter_a, 0);
      chk("t4_tmo", tmo_a, 0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      drain(0, 0);
      go(0, s);
      push(0, xp(s + 1, 5'b00101, 0, 0, 0, 0));
      push(0, xp(s + 4, 5'b01010, 0, 0, 0, 0));
      push(0, xp(s + 7, 5'b00000, 1, 1, 0, 1));
      @(negedge clk);
      st[0] = 1'b0;
      drain(0, 20);
      repeat (3) @(negedge clk);

      // start held high: back-to-back runs every 8 cycles
      go(0, s);
      for (int r = 0; r < 3; r++) begin
         push(0, xp(s + 8 * r + 1, 5'b00101, 0, 0, 0, 0));
         push(0, xp(s + 8 * r + 4, 5'b01010, 0, 0, 0, 0));
         push(0, xp(s + 8 * r + 7, 5'b00000, 1, 1, 0, 1));
      end
      wait_cyc(s + 17);
      st[0] = 1'b0;
      drain(0, 20);
      repeat (6) @(negedge clk);

      // five levels, three settle cycles
      ls_b = 5'h1F;
      go(1, s);
      push(1, xp(s + 1, 5'b10101, 0, 0, 0, 0));
      push(1, xp(s + 6, 5'b01010, 0, 0, 0, 0));
      push(1, xp(s + 11, 5'b00000, 1, 1, 0, 1));
      @(negedge clk);
      st[1] = 1'b0;
      drain(1, 30);
      repeat (3) @(negedge clk);

      // single level: odd phase has no enables and is trivially clean
      ls_c = 1'b1;
      go(2, s);
      push(2, xp(s + 1, 5'b00001, 0, 0, 0, 0));
      push(2, xp(s + 7, 5'b00000, 1, 1, 0, 1));
      @(negedge clk);
      st[2] = 1'b0;
      drain(2, 20);
      repeat (3) @(negedge clk);

      go(2, s);
      ls_c = 1'b0;
      push(2, xp(s + 1, 5'b00001, 0, 0, 0, 0));
      push(2, xp(s + 7, 5'b00001, 0, 0, 0, 1));
      push(2, xp(s + 10, 5'b00000, 1, 1, 0, 1));
      @(negedge clk);
      st[2] = 1'b0;
      wait_cyc(s + 4);
      ls_c = 1'b1;
      drain(2, 20);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
